fft32_stage_ctrl: RTL

Stage sequencer for the 32-point radix-2 FFT datapath. It generates the 3-bit `control_select` that drives the per-stage twiddle selection multiplexers, along with the working-register load and write-back enables and the input-source select. A single `start` pulse steps the butterfly array through all five stages. Completion is signalled with a one-cycle `done` pulse and a held `out_valid` level.

---
 rtl/fft32_stage_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fft32_stage_ctrl.sv
// Stage sequencer for the 32-point radix-2 FFT: walks the butterfly array through STAGES passes.
// Optional macro FFT32_CTRL_BACK2BACK_EN lets a start sampled in DONE chain straight into LOAD.
module fft32_stage_ctrl #(
  parameter int STAGES     = 5,
  parameter int BF_LATENCY = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] control_select,
  output logic       load_en,
  output logic       in_sel,
  output logic       stage_en,
  output logic       busy,
  output logic       done,
  output logic       out_valid
);

  localparam int              WC_W       = $clog2(BF_LATENCY) + 1;
  localparam logic [WC_W-1:0] WC_LAST    = WC_W'(BF_LATENCY - 1);
  localparam logic [2:0]      STAGE_LAST = 3'(STAGES - 1);

  generate
    if (STAGES < 1 || STAGES > 5) begin : g_bad_stages
      $error("fft32_stage_ctrl: STAGES must be in 1..5");
    end
    if (BF_LATENCY < 1) begin : g_bad_latency
      $error("fft32_stage_ctrl: BF_LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_stage;
  logic [2:0]      w_stage_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_nxt;
  logic            r_out_valid;
  logic            w_out_valid_nxt;
  logic            w_last_wait;

  // Butterfly outputs are settled in the final wait cycle of each stage.
  assign w_last_wait = (r_state == S_RUN) && (r_wait_cnt == WC_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_stage     <= 3'd0;
      r_wait_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stage_nxt     = r_stage;
    w_wait_nxt      = r_wait_cnt;
    w_out_valid_nxt = r_out_valid;
    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_stage_nxt     = 3'd0;
      w_wait_nxt      = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt     = S_LOAD;
            w_out_valid_nxt = 1'b0;
          end
        end
        S_LOAD: begin
          w_stage_nxt = 3'd0;
          w_wait_nxt  = '0;
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_last_wait) begin
            w_wait_nxt = '0;
            if (r_stage == STAGE_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_stage_nxt = r_stage + 3'd1;
            end
          end else begin
            w_wait_nxt = r_wait_cnt + WC_W'(1);
          end
        end
        S_DONE: begin
`ifdef FFT32_CTRL_BACK2BACK_EN
          // Chained transform: the result is being overwritten, so it never becomes valid.
          if (start) begin
            w_state_nxt     = S_LOAD;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b1;
          end
`else
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b1;
`endif
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from start/abort.
  assign control_select = (r_state == S_RUN) ? r_stage : 3'd0;
  assign load_en        = (r_state == S_LOAD);
  assign in_sel         = (r_state == S_RUN);
  assign stage_en       = w_last_wait;
  assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done           = (r_state == S_DONE);
  assign out_valid      = r_out_valid;

endmodule
